regmask_encoder: RTL and testbench

- Inverse of the register-file address decoder: converts a 32-bit register mask back into a stream of 5-bit register addresses.
- A mask (e.g. dirty/valid bits) is loaded through a valid/ready handshake. The block emits one address per accepted output beat, in priority order, clearing each bit as it is served.
- Used by writeback/spill and scoreboard-drain logic to walk set registers one at a time.

---
 rtl/regfile_pkg.sv | 26 ++
 rtl/regmask_encoder_if.sv | 28 ++
 rtl/prienc32.sv | 59 +++++
 rtl/regmask_encoder.sv | 85 ++++++++
 tb/tb_regmask_encoder.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Constants, types and helpers shared by the register-file decoder, the
// register file itself and the mask encoder.
package regfile_pkg;

    localparam int N_REGS = 32;
    localparam int ADDR_W = $clog2(N_REGS);

    typedef logic [N_REGS-1:0] reg_mask_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    // Narrower masks are zero-extended by the caller.
    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + 6'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/regmask_encoder_if.sv
// Load and output handshakes of the register-mask encoder.
interface regmask_encoder_if #(
    parameter int N_REGS = 32
);
    localparam int ADDR_W = $clog2(N_REGS);

    logic              flush;
    logic              load_valid;
    logic              load_ready;
    logic [N_REGS-1:0] load_mask;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;
    logic [ADDR_W:0]   remaining;
    logic              done;

    modport master (
        output flush, load_valid, load_mask, out_ready,
        input  load_ready, out_valid, out_addr, out_last, remaining, done
    );

    modport slave (
        input  flush, load_valid, load_mask, out_ready,
        output load_ready, out_valid, out_addr, out_last, remaining, done
    );

endinterface

// File: rtl/prienc32.sv
// Combinational priority encoder built as a recursive halving tree; reports
// the winning index, whether any bit is set, and whether exactly one is set.
module prienc32 #(
    parameter int W          = 32,
    parameter int HIGH_FIRST = 0
) (
    input  logic [W-1:0]         mask,
    output logic [$clog2(W)-1:0] addr,
    output logic                 any,
    output logic                 single
);
    localparam int AW = $clog2(W);
    localparam int H  = W / 2;

    generate
        if (W == 2) begin : g_leaf
            assign any    = mask[0] | mask[1];
            assign single = mask[0] ^ mask[1];
            if (HIGH_FIRST != 0) begin : g_hi
                assign addr = mask[1];
            end else begin : g_lo
                assign addr = mask[1] & ~mask[0];
            end
        end else begin : g_node
            logic [AW-2:0] a_lo;
            logic [AW-2:0] a_hi;
            logic          any_lo;
            logic          any_hi;
            logic          s_lo;
            logic          s_hi;

            prienc32 #(.W(H), .HIGH_FIRST(HIGH_FIRST)) u_lo (
                .mask   (mask[H-1:0]),
                .addr   (a_lo),
                .any    (any_lo),
                .single (s_lo)
            );

            prienc32 #(.W(H), .HIGH_FIRST(HIGH_FIRST)) u_hi (
                .mask   (mask[W-1:H]),
                .addr   (a_hi),
                .any    (any_hi),
                .single (s_hi)
            );

            assign any    = any_lo | any_hi;
            assign single = (s_lo & ~any_hi) | (s_hi & ~any_lo);

            // An empty subtree reports address 0, so an empty mask encodes to 0.
            if (HIGH_FIRST != 0) begin : g_hi
                assign addr = any_hi ? {1'b1, a_hi} : {1'b0, a_lo};
            end else begin : g_lo
                assign addr = any_lo ? {1'b0, a_lo} :
                              (any_hi ? {1'b1, a_hi} : '0);
            end
        end
    endgenerate

endmodule

// File: rtl/regmask_encoder.sv
// Walks a loaded register mask, emitting one set-bit index per output beat in
// priority order and clearing each bit as it is served.
//
//   state | meaning
//   IDLE  | waiting for a mask; load_ready high
//   SCAN  | emitting addresses of pending bits; out_valid high
module regmask_encoder #(
    parameter int N_REGS     = 32,
    parameter int HIGH_FIRST = 0
) (
    input logic               clk,
    input logic               rst_n,
    regmask_encoder_if.slave  bus
);
    import regfile_pkg::*;

    localparam int ADDR_W = $clog2(N_REGS);

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_SCAN = SCAN;

    logic [0:0]        state;
    logic [N_REGS-1:0] pending;
    logic [ADDR_W:0]   remaining_q;
    logic              done_q;

    logic [ADDR_W-1:0] enc_addr;
    logic              enc_any;
    logic              enc_single;
    logic              beat;
    logic [ADDR_W:0]   load_count;

    prienc32 #(.W(N_REGS), .HIGH_FIRST(HIGH_FIRST)) u_enc (
        .mask   (pending),
        .addr   (enc_addr),
        .any    (enc_any),
        .single (enc_single)
    );

    assign bus.load_ready = (state == ST_IDLE);
    assign bus.out_valid  = (state == ST_SCAN) && enc_any;
    assign bus.out_addr   = enc_addr;
    assign bus.out_last   = enc_single;
    assign bus.remaining  = remaining_q;
    assign bus.done       = done_q;

    assign beat       = bus.out_valid && bus.out_ready;
    assign load_count = (ADDR_W+1)'(popcount32(32'(bus.load_mask)));

    // Flush outranks both handshakes; a beat presented in the flush cycle is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pending     <= '0;
            remaining_q <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.flush) begin
                state       <= ST_IDLE;
                pending     <= '0;
                remaining_q <= '0;
                done_q      <= (state == ST_SCAN);
            end else if (state == ST_IDLE) begin
                if (bus.load_valid) begin
                    pending     <= bus.load_mask;
                    remaining_q <= load_count;
                    if (|bus.load_mask) begin
                        state <= ST_SCAN;
                    end else begin
                        done_q <= 1'b1;
                    end
                end
            end else if (beat) begin
                pending[enc_addr] <= 1'b0;
                remaining_q       <= remaining_q - (ADDR_W+1)'(1);
                if (enc_single) begin
                    state  <= ST_IDLE;
                    done_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_regmask_encoder.sv
// Scoreboard bench for regmask_encoder: a low-first and a high-first instance
// share the same stimulus and are checked against per-instance beat queues.
module tb_regmask_encoder;

    typedef struct packed {
        logic [4:0] addr;
        logic       last;
        logic [5:0] rem;
    } beat_t;

    typedef struct packed {
        logic       lr;
        logic       ov;
        logic [4:0] addr;
        logic       last;
        logic [5:0] rem;
        logic       done;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        load_valid = 1'b0;
    logic [31:0] load_mask = '0;
    logic        out_ready = 1'b0;
    logic        timeout_flag = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    beat_t exp_q[2][$];
    logic  done_exp[2];

    always #5 clk = ~clk;

    regmask_encoder_if bus0 ();
    regmask_encoder_if bus1 ();

    assign bus0.flush      = flush;
    assign bus0.load_valid = load_valid;
    assign bus0.load_mask  = load_mask;
    assign bus0.out_ready  = out_ready;
    assign bus1.flush      = flush;
    assign bus1.load_valid = load_valid;
    assign bus1.load_mask  = load_mask;
    assign bus1.out_ready  = out_ready;

    regmask_encoder #(.N_REGS(32), .HIGH_FIRST(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    regmask_encoder #(.N_REGS(32), .HIGH_FIRST(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    task automatic chk(input string name, input int g, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, g, act, exp, $time);
        end
    endtask

    function automatic obs_t sample(input int g);
        obs_t o;
        if (g == 0) begin
            o.lr = bus0.load_ready; o.ov = bus0.out_valid; o.addr = bus0.out_addr;
            o.last = bus0.out_last; o.rem = bus0.remaining; o.done = bus0.done;
        end else begin
            o.lr = bus1.load_ready; o.ov = bus1.out_valid; o.addr = bus1.out_addr;
            o.last = bus1.out_last; o.rem = bus1.remaining; o.done = bus1.done;
        end
        return o;
    endfunction

    // Reference: list set bits in index order; the high-first instance walks it backwards.
    function automatic void push_mask(input logic [31:0] m);
        int    idx[$];
        int    n;
        beat_t b;
        for (int i = 0; i < 32; i++) if (m[i]) idx.push_back(i);
        n = idx.size();
        for (int k = 0; k < n; k++) begin
            b.rem  = 6'(n - k);
            b.last = (k == n - 1);
            b.addr = 5'(idx[k]);
            exp_q[0].push_back(b);
            b.addr = 5'(idx[n - 1 - k]);
            exp_q[1].push_back(b);
        end
    endfunction

    // Monitor: compares every cycle, pops on accepted beats, predicts done.
    always begin
        @(negedge clk or negedge rst_n);
        if (!rst_n) begin
            #1;
            for (int g = 0; g < 2; g++) begin
                obs_t o;
                o = sample(g);
                chk("rst_load_ready", g, 32'(o.lr), 32'd1);
                chk("rst_out_valid", g, 32'(o.ov), 32'd0);
                chk("rst_out_addr", g, 32'(o.addr), 32'd0);
                chk("rst_out_last", g, 32'(o.last), 32'd0);
                chk("rst_remaining", g, 32'(o.rem), 32'd0);
                chk("rst_done", g, 32'(o.done), 32'd0);
                exp_q[g].delete();
                done_exp[g] = 1'b0;
            end
        end else begin
            chk("timeout", 0, 32'(timeout_flag), 32'd0);
            for (int g = 0; g < 2; g++) begin
                obs_t  o;
                beat_t e;
                logic  busy;
                logic  nd;
                o    = sample(g);
                busy = (exp_q[g].size() != 0);
                chk("done", g, 32'(o.done), 32'(done_exp[g]));
                chk("load_ready", g, 32'(o.lr), 32'(!busy));
                chk("out_valid", g, 32'(o.ov), 32'(busy));
                if (busy) begin
                    e = exp_q[g][0];
                    chk("out_addr", g, 32'(o.addr), 32'(e.addr));
                    chk("out_last", g, 32'(o.last), 32'(e.last));
                    chk("remaining", g, 32'(o.rem), 32'(e.rem));
                end else begin
                    e = '0;
                    chk("idle_out_addr", g, 32'(o.addr), 32'd0);
                    chk("idle_out_last", g, 32'(o.last), 32'd0);
                    chk("idle_remaining", g, 32'(o.rem), 32'd0);
                end
                nd = 1'b0;
                if (flush) begin
                    nd = busy;
                    exp_q[g].delete();
                end else if (busy && out_ready) begin
                    void'(exp_q[g].pop_front());
                    nd = e.last;
                end else if (!busy && load_valid && load_mask == 32'd0) begin
                    nd = 1'b1;
                end
                done_exp[g] = nd;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic busy_any();
        return (exp_q[0].size() != 0) || (exp_q[1].size() != 0);
    endfunction

    task automatic load(input logic [31:0] m);
        int w;
        w = 0;
        while (busy_any() && w < 400) begin
            step();
            w++;
        end
        if (w >= 400) timeout_flag = 1'b1;
        load_valid = 1'b1;
        load_mask  = m;
        step();
        load_valid = 1'b0;
        if (m != 32'd0) push_mask(m);
    endtask

    // mode 0: always ready, 1: toggle starting high, 2: random
    task automatic drain(input int mode, input int flush_at);
        int cnt;
        cnt = 0;
        while (busy_any() && cnt < 400) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cnt % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            flush = (cnt == flush_at);
            step();
            cnt++;
        end
        flush     = 1'b0;
        out_ready = 1'b0;
        if (cnt >= 400) timeout_flag = 1'b1;
    endtask

    initial begin
        logic [31:0] m;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        load(32'h8000_0005); drain(0, -1);
        load(32'h8000_0005); drain(1, -1);
        load(32'h0000_0000); step(); step();
        load(32'hFFFF_FFFF); drain(0, -1);

        load(32'h0000_00F0);
        out_ready = 1'b1; step();
        flush = 1'b1; step();
        flush = 1'b0; out_ready = 1'b0; step();
        load(32'h0000_0002); drain(0, -1);

        load(32'h0003_0C00);
        load_valid = 1'b1; load_mask = 32'h1; out_ready = 1'b0;
        step(); step();
        load_valid = 1'b0; load_mask = '0;
        drain(1, -1);

        load(32'h0000_FF00);
        out_ready = 1'b1; step(); step();
        out_ready = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #4;
        step(); step();
        rst_n = 1'b1;
        step();
        load(32'h0000_0010); drain(0, -1);

        repeat (60) begin
            case ($urandom_range(0, 5))
                0:       m = 32'd0;
                1:       m = 32'd1 << $urandom_range(0, 31);
                2:       m = 32'hFFFF_FFFF;
                3:       m = $urandom() & $urandom() & $urandom();
                default: m = $urandom();
            endcase
            load(m);
            if (m != 32'd0 && $urandom_range(0, 3) == 0) begin
                load_valid = 1'b1; load_mask = $urandom() | 32'h1; out_ready = 1'b0;
                step(); step();
                load_valid = 1'b0; load_mask = '0;
            end
            drain(2, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1);
        end
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule
